// File: rtl/cc_game_ctrl.sv
// Game-control stage for the player light column: button conditioning,
// IDLE/PLAY/OVER state machine, light-aligned move tick, collision and score.
module cc_game_ctrl #(
  parameter int ROWS    = 8,
  parameter int TICK_W  = 7,
  parameter int SCORE_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_up_n,
  input  logic               key_start_n,
  input  logic [ROWS-1:0]    player,
  input  logic [ROWS-1:0]    obstacle,
  output logic               ctrl,
  output logic               ongoing,
  output logic               gameOver,
  output logic               tick,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_ILL  = 2'b11
  } state_e;

  logic [1:0]         up_sync_q;
  logic [1:0]         start_sync_q;
  logic               start_prev_q;
  logic               ctrl_q;
  state_e             state_q, state_d;
  logic [TICK_W-1:0]  cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               first_q, first_d;

  logic start_pressed_s;
  logic start_evt_s;
  logic collision_s;
  logic tick_s;

  assign start_pressed_s = ~start_sync_q[1];
  assign start_evt_s     = start_pressed_s & ~start_prev_q;
  assign collision_s     = |(player & obstacle);
  assign tick_s          = (state_q == ST_PLAY) && (cnt_q == '0);

  // Button synchronizers and registered move-up level.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_sync_q    <= 2'b11;
      start_sync_q <= 2'b11;
      start_prev_q <= 1'b0;
      ctrl_q       <= 1'b0;
    end else begin
      up_sync_q    <= {up_sync_q[0], key_up_n};
      start_sync_q <= {start_sync_q[0], key_start_n};
      start_prev_q <= start_pressed_s;
      ctrl_q       <= ~up_sync_q[1];
    end
  end

  // Game state, tick counter and score registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      score_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      first_q <= first_d;
    end
  end

  // Next-state logic; first_q masks the tick that coincides with game entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    score_d = score_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (start_evt_s) begin
          state_d = ST_PLAY;
          score_d = '0;
          first_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (collision_s) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_PLAY;
          cnt_d   = cnt_q + TICK_W'(1);
          if (tick_s) begin
            first_d = 1'b0;
            if (!first_q && (score_q != '1)) begin
              score_d = score_q + SCORE_W'(1);
            end else begin
              score_d = score_q;
            end
          end else begin
            first_d = first_q;
          end
        end
      end
      ST_OVER: begin
        if (start_evt_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ctrl      = ctrl_q;
  assign ongoing   = (state_q == ST_PLAY) || (state_q == ST_OVER);
  assign gameOver  = (state_q == ST_OVER);
  assign tick      = tick_s;
  assign score     = score_q;
  assign state_dbg = state_q;

endmodule
